// File: rtl/reg_file_dumper_if.sv
// Bus bundle between the register-file dumper and its host/stream consumer.
interface reg_file_dumper_if #(
  parameter int pw = 3,
  parameter int dw = 8
);
  logic          start;
  logic          abort;
  logic [pw-1:0] first_addr;
  logic [pw-1:0] last_addr;
  logic [pw-1:0] rd_addr;
  logic [dw-1:0] rd_data;
  logic [dw-1:0] out_data;
  logic [pw-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  // Host side: issues dump requests, owns the register file, consumes beats.
  modport master (
    output start, abort, first_addr, last_addr, rd_data, out_ready,
    input  rd_addr, out_data, out_addr, out_valid, busy, done
  );

  // Dumper side.
  modport slave (
    input  start, abort, first_addr, last_addr, rd_data, out_ready,
    output rd_addr, out_data, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Read-side sequencer: walks an inclusive (wrapping) address range of the
// register file and streams each value out over valid/ready, tagged with
// its address. One beat every two cycles at best (fetch, then send).
module reg_file_dumper #(
  parameter int pw = 3,
  parameter int dw = 8
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_dumper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [pw-1:0] ptr;
  logic [pw-1:0] last;
  logic [dw-1:0] out_data_r;
  logic [pw-1:0] out_addr_r;
  logic          out_valid_r;

  // Read port follows the walking pointer; read data is combinational.
  assign bus.rd_addr   = ptr;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = (state == FETCH) || (state == SEND);
  assign bus.done      = (state == DONE);

  // Sequencer: range capture, fetch/send alternation, abort and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      last        <= '0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            ptr   <= bus.first_addr;
            last  <= bus.last_addr;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (bus.abort) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end else begin
            out_data_r  <= bus.rd_data;
            out_addr_r  <= ptr;
            out_valid_r <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a same-cycle handshake; the held beat is dropped.
          if (bus.abort) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (ptr == last) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
